pc_seq: RTL
===========

# pc_seq

Parametrised program-counter sequencer; successor to the fixed 16-bit incrementing PC. It adds configurable width and step, a reset vector, absolute and PC-relative branches, and an optional hardware return-address stack for call/return. It sits in the fetch stage and drives the instruction-memory address. The decode/branch unit issues one operation per enabled cycle.

## Interface
- WIDTH, 16, PC and target width in bits
- STEP, 2, sequential increment in bytes
- RESET_VECTOR, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (≥2; used only with PC_RAS_EN)

- I_clk  in  1  clock; all state changes on the rising edge
- I_reset  in  1  synchronous, active-high reset
- I_enable  in  1  advance strobe; when low, all state holds
- I_op  in  3  operation: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5–7 HOLD
- I_target  in  WIDTH  absolute target (JUMP/CALL) or two's-complement offset (BRANCH)
- O_pc  out  WIDTH  current PC (registered)
- O_ras_count  out  $clog2(RAS_DEPTH+1)  valid stack entries
- O_ras_overflow  out  1  sticky: CALL issued while stack was full
- O_ras_underflow  out  1  sticky: RET issued while stack was empty

## Operation
- Reset (overrides I_enable): O_pc=RESET_VECTOR, O_ras_count=0, both sticky flags=0. Stack contents are don't-care.
- I_enable=0: O_pc, stack, count and flags all hold, whatever I_op is.
- I_enable=1, by I_op:
  - NEXT: O_pc ← O_pc+STEP
  - JUMP: O_pc ← I_target
  - BRANCH: O_pc ← O_pc+I_target (offset relative to the current PC, not PC+STEP)
  - CALL: push O_pc+STEP; O_pc ← I_target
  - RET: pop top; O_pc ← popped value
  - HOLD (5–7): no change to any state
- Arithmetic is modulo 2^WIDTH. Wrap-around is silent. No alignment is enforced.
- Stack is LIFO, implemented as a circular buffer with a top pointer and count.
- CALL when count==RAS_DEPTH:
  - the oldest entry is overwritten
  - count stays RAS_DEPTH
  - O_ras_overflow sets
- RET when count==0:
  - O_pc ← O_pc+STEP (falls through)
  - pointer and count unchanged
  - O_ras_underflow sets
- Sticky flags clear only on reset.
- CALL pushes the address derived from the pre-update O_pc.

## Timing
- Single cycle: the op sampled at edge N is visible on O_pc after edge N.
- O_ras_count and the flags update on the same edge as O_pc.
- Back-to-back CALL/RET on consecutive cycles are legal. A RET immediately after a CALL returns that CALL's link address.
- Reset asserted mid-sequence takes effect on the next edge and discards all stack contents.
- No combinational path from inputs to outputs.

## Configuration
- PC_RAS_EN defined: the return-address stack is built as described.
- PC_RAS_EN undefined:
  - no stack storage is built
  - CALL behaves as JUMP (link address discarded)
  - RET behaves as NEXT
  - O_ras_count, O_ras_overflow and O_ras_underflow are tied to 0

## Structure
- Package pc_pkg:
  - op-code localparams (OP_NEXT, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET)
  - op width constant (3)
- Sub-module pc_ras:
  - parameters WIDTH, RAS_DEPTH
  - push/pop strobes, push data, pop data
  - count, full, empty
  - instantiated only under PC_RAS_EN
- pc_seq holds the PC register, next-PC mux and sticky flags.

## Test plan
- Reset, then 3× NEXT (WIDTH=16, STEP=2, RESET_VECTOR=0x0100) -> O_pc 0x0100, 0x0102, 0x0104, 0x0106.
- Enable and wrap:
  - I_enable=0 for 3 cycles with op JUMP 0x1234 -> O_pc holds
  - then JUMP 0xFFFE, NEXT -> O_pc 0xFFFE, then 0x0000
- BRANCH offsets:
  - from O_pc=0x0040, offset 0xFFF0 -> 0x0030
  - then offset 0x0010 -> 0x0040
- CALL/RET nesting:
  - at 0x0010 CALL 0x0200, then CALL 0x0300 -> count 2
  - RET -> O_pc 0x0202, RET -> O_pc 0x0012, count 0, flags 0
- Overflow and underflow, RAS_DEPTH=4:
  - 5 CALLs from 0x0000,0x0100,…,0x0400 -> overflow=1, count=4
  - 4 RETs -> 0x0402, 0x0302, 0x0202, 0x0102
  - 5th RET -> O_pc+2, underflow=1
  - reset -> both flags clear
- Build without PC_RAS_EN:
  - CALL 0x0200 -> O_pc 0x0200
  - RET -> O_pc 0x0202
  - O_ras_count and both flags stay 0

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: op-codes and shared constants for the program-counter sequencer
package pc_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_NEXT   = 3'd0;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'd1;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
  localparam logic [OP_W-1:0] OP_RET    = 3'd4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular-buffer return-address stack; a push when full overwrites the oldest entry
module pc_ras import pc_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1),
  localparam int PW = $clog2(RAS_DEPTH)
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  // ptr names the next free slot; when full that slot holds the oldest entry
  assign ptr_inc  = ptr == PW'(RAS_DEPTH - 1) ? '0 : ptr + 1'b1;
  assign ptr_dec  = ptr == '0 ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
  assign full     = count == CW'(RAS_DEPTH);
  assign empty    = count == '0;
  assign pop_data = mem[ptr_dec];
  always_ff @(posedge I_clk)
    if (push) mem[ptr] <= push_data;
  always_ff @(posedge I_clk)
    if (I_reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr_inc;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with jumps, relative branches and call/return.
// The return-address stack is built only when PC_RAS_EN is defined.
module pc_seq import pc_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int STEP = 2,
  parameter int RESET_VECTOR = 0,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_enable,
  input  logic [OP_W-1:0]  I_op,
  input  logic [WIDTH-1:0] I_target,
  output logic [WIDTH-1:0] O_pc,
  output logic [CW-1:0]    O_ras_count,
  output logic             O_ras_overflow,
  output logic             O_ras_underflow
);
  logic [WIDTH-1:0] pc_q, pc_d, seq_pc, ret_pc;
  assign seq_pc = pc_q + WIDTH'(STEP);
`ifdef PC_RAS_EN
  logic is_call, is_ret, full, empty, ovf_q, unf_q;
  logic [WIDTH-1:0] pop_data;
  assign is_call = I_enable && I_op == OP_CALL;
  assign is_ret  = I_enable && I_op == OP_RET;
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .I_clk(I_clk), .I_reset(I_reset), .push(is_call), .pop(is_ret),
    .push_data(seq_pc), .pop_data(pop_data), .count(O_ras_count),
    .full(full), .empty(empty)
  );
  // an empty-stack return falls through to the sequential address
  assign ret_pc = empty ? seq_pc : pop_data;
  always_ff @(posedge I_clk)
    if (I_reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (is_call && full) ovf_q <= 1'b1;
      if (is_ret && empty) unf_q <= 1'b1;
    end
  assign O_ras_overflow  = ovf_q;
  assign O_ras_underflow = unf_q;
`else
  assign ret_pc          = seq_pc;
  assign O_ras_count     = '0;
  assign O_ras_overflow  = 1'b0;
  assign O_ras_underflow = 1'b0;
`endif
  always_comb
    pc_d = !I_enable                            ? pc_q :
           I_op == OP_NEXT                      ? seq_pc :
           I_op == OP_JUMP || I_op == OP_CALL   ? I_target :
           I_op == OP_BRANCH                    ? pc_q + I_target :
           I_op == OP_RET                       ? ret_pc : pc_q;
  always_ff @(posedge I_clk)
    pc_q <= I_reset ? WIDTH'(RESET_VECTOR) : pc_d;
  assign O_pc = pc_q;
endmodule
